refresh_scheduler: RTL and testbench

// Consumes the level output of the refresh timer (REFRESH_STROBE, square wave)
// and turns each rising edge into one owed DRAM AUTO REFRESH. Keeps a count of

---
 rtl/refresh_scheduler_if.sv | 33 +++
 rtl/refresh_scheduler.sv | 128 ++++++++++++
 tb/tb_refresh_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/refresh_scheduler_if.sv
// Command-bus arbitration and status signals between the refresh scheduler
// (slave) and the DRAM controller / refresh timer side (master).
interface refresh_scheduler_if #(
  parameter int PEND_W = 4
);
  // Handshake: RFSH_REQ rises only from idle and stays high, never withdrawn,
  // until RFSH_GNT is sampled high on a clock edge. The request drops on that
  // same edge and the scheduler owns the bus (RFSH_BUSY) until its burst ends.
  // RFSH_GNT is a level that is ignored whenever no request is outstanding.
  logic              REFRESH_STROBE;
  logic              CTRL_IDLE;
  logic              RFSH_GNT;
  logic              RFSH_REQ;
  logic              RFSH_URGENT;
  logic              RFSH_BUSY;
  logic              CMD_VALID;
  logic [1:0]        CMD;
  logic [PEND_W-1:0] PENDING;
  logic              OVERFLOW;
  logic [2:0]        fsm_state;

  modport master (
    output REFRESH_STROBE, CTRL_IDLE, RFSH_GNT,
    input  RFSH_REQ, RFSH_URGENT, RFSH_BUSY, CMD_VALID, CMD, PENDING, OVERFLOW,
    input  fsm_state
  );

  modport slave (
    input  REFRESH_STROBE, CTRL_IDLE, RFSH_GNT,
    output RFSH_REQ, RFSH_URGENT, RFSH_BUSY, CMD_VALID, CMD, PENDING, OVERFLOW,
    output fsm_state
  );
endinterface

// File: rtl/refresh_scheduler.sv
// Turns refresh-timer strobe edges into a backlog of owed AUTO REFRESH commands
// and drains it as PRECHARGE ALL followed by tRFC-spaced AUTO REFRESH bursts.
module refresh_scheduler #(
  parameter int T_RP        = 3,
  parameter int T_RFC       = 8,
  parameter int PEND_W      = 4,
  parameter int MAX_PENDING = 8,
  parameter int URGENT_LVL  = 6
) (
  input  logic               CLK,
  input  logic               RST,
  refresh_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    PRE      = 3'd2,
    WAIT_RP  = 3'd3,
    AR       = 3'd4,
    WAIT_RFC = 3'd5
  } state_t;

  localparam int CNT_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The first wait cycle is entered directly, so the counter holds the
  // number of wait cycles still to come after it.
  localparam int RP_LOAD_I  = (T_RP  > 1) ? T_RP  - 2 : 0;
  localparam int RFC_LOAD_I = (T_RFC > 1) ? T_RFC - 2 : 0;
  localparam logic [CNT_W-1:0]  RP_LOAD  = RP_LOAD_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  RFC_LOAD = RFC_LOAD_I[CNT_W-1:0];
  localparam logic [PEND_W-1:0] MAX_P    = MAX_PENDING[PEND_W-1:0];
  localparam logic [PEND_W-1:0] URG_P    = URGENT_LVL[PEND_W-1:0];

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PEND_W-1:0] pending_q, pending_nxt;
  logic              ovf_q, ovf_nxt;
  logic              strobe_prev;
  logic              rise;
  logic              dec;
  logic              req_q, urgent_q, busy_q, valid_q;
  logic [1:0]        cmd_q;

  // Backlog bookkeeping; an AR leaving the AR state cancels a coincident edge.
  always_comb begin
    rise        = bus.REFRESH_STROBE & ~strobe_prev;
    dec         = (state == AR);
    pending_nxt = pending_q;
    ovf_nxt     = ovf_q;
    if (rise && !dec) begin
      if (pending_q == MAX_P) ovf_nxt = 1'b1;
      else                    pending_nxt = pending_q + 1'b1;
    end else if (!rise && dec) begin
      pending_nxt = pending_q - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:
        if (pending_q != '0 && (bus.CTRL_IDLE || urgent_q)) state_nxt = REQ;
      REQ:
        if (bus.RFSH_GNT) state_nxt = PRE;
      PRE:
        if (T_RP == 1) state_nxt = AR;
        else begin
          state_nxt = WAIT_RP;
          cnt_nxt   = RP_LOAD;
        end
      WAIT_RP:
        if (cnt == '0) state_nxt = AR;
        else           cnt_nxt   = cnt - 1'b1;
      AR:
        if (T_RFC == 1) state_nxt = (pending_nxt != '0) ? AR : IDLE;
        else begin
          state_nxt = WAIT_RFC;
          cnt_nxt   = RFC_LOAD;
        end
      WAIT_RFC:
        // Edges that arrived during the burst keep it going without a new PRE.
        if (cnt == '0) state_nxt = (pending_nxt != '0) ? AR : IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      cnt         <= '0;
      pending_q   <= '0;
      ovf_q       <= 1'b0;
      strobe_prev <= 1'b1;
      req_q       <= 1'b0;
      urgent_q    <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      cmd_q       <= 2'b00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending_q   <= pending_nxt;
      ovf_q       <= ovf_nxt;
      strobe_prev <= bus.REFRESH_STROBE;
      req_q       <= (state_nxt == REQ);
      urgent_q    <= (pending_nxt >= URG_P);
      busy_q      <= (state_nxt == PRE) || (state_nxt == WAIT_RP) ||
                     (state_nxt == AR)  || (state_nxt == WAIT_RFC);
      valid_q     <= (state_nxt == PRE) || (state_nxt == AR);
      cmd_q       <= (state_nxt == PRE) ? 2'b01 :
                     (state_nxt == AR)  ? 2'b10 : 2'b00;
    end
  end

  assign bus.RFSH_REQ    = req_q;
  assign bus.RFSH_URGENT = urgent_q;
  assign bus.RFSH_BUSY   = busy_q;
  assign bus.CMD_VALID   = valid_q;
  assign bus.CMD         = cmd_q;
  assign bus.PENDING     = pending_q;
  assign bus.OVERFLOW    = ovf_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: vector table for the basic burst and
// grant-held cases, hand sequences for backlog, overflow, merging and reset.
module tb_refresh_scheduler;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  refresh_scheduler_if #(.PEND_W(4)) bus ();

  refresh_scheduler dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       strobe;
    logic       idle;
    logic       gnt;
    logic       req;
    logic       urgent;
    logic       busy;
    logic       valid;
    logic [1:0] cmd;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {bus.RFSH_REQ, bus.RFSH_URGENT, bus.RFSH_BUSY, bus.CMD_VALID,
            bus.CMD, bus.PENDING, bus.OVERFLOW};
  endfunction

  task automatic add(input logic rst, input logic s, input logic i, input logic g,
                     input logic req, input logic busy, input logic valid,
                     input logic [1:0] cmd, input logic [3:0] pend);
    vec_t v;
    v.rst = rst; v.strobe = s; v.idle = i; v.gnt = g;
    v.req = req; v.urgent = 1'b0; v.busy = busy; v.valid = valid;
    v.cmd = cmd; v.pend = pend; v.ovf = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic rise();
    bus.REFRESH_STROBE = 1'b1;
    tick();
    bus.REFRESH_STROBE = 1'b0;
    tick();
  endtask

  // Grants a pending request and follows the burst; AR times are expected at
  // PRE+T_RP and then every T_RFC cycles.
  task automatic run_burst(input string name, input int n_ar);
    int t;
    int pre_n;
    int ar_n;
    logic [31:0] exp_t;
    exp_q.delete();
    t = 0; pre_n = 0; ar_n = 0;
    bus.RFSH_GNT = 1'b1;
    tick();
    bus.RFSH_GNT = 1'b0;
    while (t < 200) begin
      if (bus.CMD_VALID && bus.CMD == 2'b01) begin
        pre_n++;
        for (int k = 0; k < n_ar; k++) exp_q.push_back(32'(t + 3 + 8 * k));
      end
      if (bus.CMD_VALID && bus.CMD == 2'b10) begin
        ar_n++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s unexpected_ar actual=%0d expected=none", name, t);
        end else begin
          exp_t = exp_q.pop_front();
          check({name, " ar_time"}, t, int'(exp_t));
        end
      end
      if (!bus.RFSH_BUSY) break;
      tick();
      t++;
    end
    check({name, " pre_count"}, pre_n, 1);
    check({name, " ar_count"}, ar_n, n_ar);
    check({name, " busy_end"}, int'(bus.RFSH_BUSY), 0);
    check({name, " pending_end"}, int'(bus.PENDING), 0);
    check({name, " idle_cycles"}, t, 3 + 8 * n_ar);
  endtask

  initial begin
    int n;
    int bad;
    logic [10:0] exp_v;

    // Single refresh, grant one cycle after REQ.
    add(0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    add(0, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 1, 1, 0, 0, 0, 0, 2'b00, 1);
    add(1, 1, 1, 0, 1, 0, 0, 2'b00, 1);
    add(1, 1, 1, 1, 0, 1, 1, 2'b01, 1);
    add(1, 0, 1, 0, 0, 1, 0, 2'b00, 1);
    add(1, 0, 1, 0, 0, 1, 0, 2'b00, 1);
    add(1, 0, 1, 0, 0, 1, 1, 2'b10, 1);
    for (int k = 0; k < 7; k++) add(1, 0, 1, 0, 0, 1, 0, 2'b00, 0);
    add(1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    add(1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
    // Grant held high in idle and throughout the burst.
    add(1, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    add(1, 1, 1, 1, 0, 0, 0, 2'b00, 1);
    add(1, 1, 1, 1, 1, 0, 0, 2'b00, 1);
    add(1, 1, 1, 1, 0, 1, 1, 2'b01, 1);
    add(1, 0, 1, 1, 0, 1, 0, 2'b00, 1);
    add(1, 0, 1, 1, 0, 1, 0, 2'b00, 1);
    add(1, 0, 1, 1, 0, 1, 1, 2'b10, 1);
    for (int k = 0; k < 7; k++) add(1, 0, 1, 1, 0, 1, 0, 2'b00, 0);
    add(1, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    add(1, 0, 1, 1, 0, 0, 0, 2'b00, 0);
    add(1, 0, 1, 0, 0, 0, 0, 2'b00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      RST                = vecs[i].rst;
      bus.REFRESH_STROBE = vecs[i].strobe;
      bus.CTRL_IDLE      = vecs[i].idle;
      bus.RFSH_GNT       = vecs[i].gnt;
      tick();
      exp_v = {vecs[i].req, vecs[i].urgent, vecs[i].busy, vecs[i].valid,
               vecs[i].cmd, vecs[i].pend, vecs[i].ovf};
      check($sformatf("vec%0d", i), int'(outs()), int'(exp_v));
    end

    // Backlog builds with controller busy until the urgent level.
    bus.CTRL_IDLE = 1'b0;
    for (int k = 0; k < 5; k++) rise();
    check("s2 req_below_urgent", int'(bus.RFSH_REQ), 0);
    check("s2 pending5", int'(bus.PENDING), 5);
    check("s2 urgent_below", int'(bus.RFSH_URGENT), 0);
    bus.REFRESH_STROBE = 1'b1;
    tick();
    check("s2 pending6", int'(bus.PENDING), 6);
    check("s2 urgent_at6", int'(bus.RFSH_URGENT), 1);
    check("s2 req_not_yet", int'(bus.RFSH_REQ), 0);
    bus.REFRESH_STROBE = 1'b0;
    tick();
    check("s2 req_urgent", int'(bus.RFSH_REQ), 1);
    run_burst("s2", 6);
    check("s2 urgent_end", int'(bus.RFSH_URGENT), 0);

    // Saturation and sticky overflow.
    for (int k = 0; k < 8; k++) rise();
    check("s3 pending_sat", int'(bus.PENDING), 8);
    check("s3 no_overflow_yet", int'(bus.OVERFLOW), 0);
    check("s3 req_held", int'(bus.RFSH_REQ), 1);
    rise();
    check("s3 pending_hold", int'(bus.PENDING), 8);
    check("s3 overflow_set", int'(bus.OVERFLOW), 1);
    run_burst("s3", 8);
    check("s3 overflow_sticky", int'(bus.OVERFLOW), 1);

    // Edge coinciding with AR, and edge during the last tRFC window.
    bus.CTRL_IDLE = 1'b1;
    rise();
    check("s4 req", int'(bus.RFSH_REQ), 1);
    bus.RFSH_GNT = 1'b1;
    tick();
    bus.RFSH_GNT = 1'b0;
    check("s4 pre", int'(bus.CMD), 1);
    n = 0;
    while (!(bus.CMD_VALID && bus.CMD == 2'b10) && n < 10) begin
      tick();
      n++;
    end
    check("s4 first_ar_latency", n, 3);
    bus.REFRESH_STROBE = 1'b1;
    tick();
    bus.REFRESH_STROBE = 1'b0;
    check("s4 pending_coincident", int'(bus.PENDING), 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.CMD_VALID || !bus.RFSH_BUSY) bad++;
    end
    check("s4 rfc_gap1", bad, 0);
    tick();
    check("s4 second_ar", int'({bus.CMD_VALID, bus.CMD}), 3'b110);
    tick();
    check("s4 pending_after_ar2", int'(bus.PENDING), 0);
    tick();
    bus.REFRESH_STROBE = 1'b1;
    tick();
    bus.REFRESH_STROBE = 1'b0;
    check("s4 pending_late_edge", int'(bus.PENDING), 1);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.CMD_VALID || !bus.RFSH_BUSY) bad++;
    end
    check("s4 rfc_gap2", bad, 0);
    tick();
    check("s4 third_ar", int'({bus.CMD_VALID, bus.CMD}), 3'b110);
    repeat (7) tick();
    check("s4 busy_last", int'(bus.RFSH_BUSY), 1);
    tick();
    check("s4 end", int'(outs()), int'(11'b000_0_00_0000_1));

    // Reset during WAIT_RP with strobe held high through reset.
    bus.CTRL_IDLE = 1'b0;
    rise();
    rise();
    bus.REFRESH_STROBE = 1'b1;
    tick();
    check("s5 pending3", int'(bus.PENDING), 3);
    bus.CTRL_IDLE = 1'b1;
    tick();
    check("s5 req", int'(bus.RFSH_REQ), 1);
    bus.RFSH_GNT = 1'b1;
    tick();
    bus.RFSH_GNT = 1'b0;
    check("s5 pre", int'({bus.CMD_VALID, bus.CMD}), 3'b101);
    tick();
    check("s5 wait_rp", int'(outs()), int'(11'b001_0_00_0011_1));
    RST = 1'b0;
    tick();
    check("s5 reset_outs", int'(outs()), 0);
    check("s5 reset_state", int'(bus.fsm_state), 0);
    RST = 1'b1;
    tick();
    check("s5 no_edge_exit", int'(bus.PENDING), 0);
    tick();
    check("s5 still_idle", int'(outs()), 0);
    bus.REFRESH_STROBE = 1'b0;
    tick();
    bus.REFRESH_STROBE = 1'b1;
    tick();
    check("s5 edge_after_reset", int'(bus.PENDING), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
